// File: rtl/led_stretch_pkg.sv
// rtl/led_stretch_pkg.sv - shared state type and default timing for the LED pulse stretcher
package led_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } stretch_state_t;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_ON_CYCLES   = 10_000_000;
  localparam int DEF_OFF_CYCLES  = 5_000_000;
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_QUEUE_DEPTH = 7;

endpackage

// File: rtl/led_stretch_chan.sv
// rtl/led_stretch_chan.sv - one event->LED channel: IDLE/ON/OFF FSM, timer, pending logic (LED_QUEUE_EN selects queueing)
module led_stretch_chan
  import led_stretch_pkg::*;
#(
  parameter int ON_CYCLES   = DEF_ON_CYCLES,
  parameter int OFF_CYCLES  = DEF_OFF_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  output logic led,
  output logic busy,
  output logic drop
);

  localparam logic [CNT_W-1:0] ON_RELOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_RELOAD = CNT_W'(OFF_CYCLES - 1);

`ifdef LED_QUEUE_EN
  localparam int                PEND_W   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(QUEUE_DEPTH);
`else
  localparam int                PEND_W   = 1;
`endif

  // Reject parameter sets the timer or pending counter cannot represent
  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || QUEUE_DEPTH < 1 || QUEUE_DEPTH > 255 ||
      (ON_CYCLES - 1) >= (2 ** CNT_W) || (OFF_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_params
    $error("led_stretch_chan: invalid timing/queue parameters");
  end

  stretch_state_t    state;
  logic [CNT_W-1:0]  timer;
  logic [PEND_W-1:0] pending;

  // Channel FSM with registered led/busy/drop; outputs are updated together with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      pending <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (evt) begin
            state <= ST_ON;
            timer <= ON_RELOAD;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end

        ST_ON: begin
`ifdef LED_QUEUE_EN
          // Events during ON are queued, never extend the current blink
          if (evt) begin
            if (pending == PEND_MAX) drop <= 1'b1;
            else                     pending <= pending + PEND_W'(1);
          end
          if (timer == '0) begin
            state <= ST_OFF;
            timer <= OFF_RELOAD;
            led   <= 1'b0;
          end else begin
            timer <= timer - CNT_W'(1);
          end
`else
          // Retrigger wins over expiry so a late event still extends the blink
          if (evt) begin
            timer <= ON_RELOAD;
          end else if (timer == '0) begin
            state <= ST_OFF;
            timer <= OFF_RELOAD;
            led   <= 1'b0;
          end else begin
            timer <= timer - CNT_W'(1);
          end
`endif
        end

        ST_OFF: begin
`ifdef LED_QUEUE_EN
          if (timer == '0) begin
            if (pending != '0 || evt) begin
              state <= ST_ON;
              timer <= ON_RELOAD;
              led   <= 1'b1;
              // A new event arriving as one is consumed leaves the count unchanged
              if (pending != '0 && !evt) pending <= pending - PEND_W'(1);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - CNT_W'(1);
            if (evt) begin
              if (pending == PEND_MAX) drop <= 1'b1;
              else                     pending <= pending + PEND_W'(1);
            end
          end
`else
          if (timer == '0) begin
            if (pending != '0 || evt) begin
              state   <= ST_ON;
              timer   <= ON_RELOAD;
              led     <= 1'b1;
              pending <= '0;
              // Only one blink can follow; a second event in the gap is lost
              if (pending != '0 && evt) drop <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - CNT_W'(1);
            if (evt) begin
              if (pending != '0) drop <= 1'b1;
              else               pending <= 1'b1;
            end
          end
`endif
        end

        default: begin
          state   <= ST_IDLE;
          timer   <= '0;
          pending <= '0;
          led     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - multi-channel event pulse to LED blink stretcher (optional LED_QUEUE_EN)
module led_pulse_stretcher
  import led_stretch_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int ON_CYCLES   = DEF_ON_CYCLES,
  parameter int OFF_CYCLES  = DEF_OFF_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] evt_pulse,
  output logic [CHANNELS-1:0] led_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] drop
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_stretch_chan #(
      .ON_CYCLES   (ON_CYCLES),
      .OFF_CYCLES  (OFF_CYCLES),
      .CNT_W       (CNT_W),
      .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .evt  (evt_pulse[i]),
      .led  (led_out[i]),
      .busy (busy[i]),
      .drop (drop[i])
    );
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb/tb_led_pulse_stretcher.sv - directed self-checking bench for led_pulse_stretcher
module tb_led_pulse_stretcher;

  logic       clk;
  logic       rst;
  logic [3:0] evt_pulse;
  logic [3:0] led_out;
  logic [3:0] busy;
  logic [3:0] drop;

  int errors;
  int checks;
  int t;

  led_pulse_stretcher #(
    .CHANNELS    (4),
    .ON_CYCLES   (4),
    .OFF_CYCLES  (3),
    .CNT_W       (8),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .evt_pulse (evt_pulse),
    .led_out   (led_out),
    .busy      (busy),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    t = t + 1;
  endtask

  task automatic begin_test();
    rst       = 1'b1;
    evt_pulse = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t   = 0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    evt_pulse = 4'h0;
    t         = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      evt_pulse = (i % 2 == 0) ? 4'hF : 4'h0;
      checks++;
      if (led_out !== 4'h0 || busy !== 4'h0 || drop !== 4'h0) begin
        errors++;
        $display("FAIL reset cyc%0d: led=%h busy=%h drop=%h, required all 0", t, led_out, busy, drop);
      end
    end
    evt_pulse = 4'h0;
  endtask

  task automatic test_single_blink();
    logic e_led, e_busy;
    begin_test();
    for (int i = 0; i < 22; i++) begin
      step();
      evt_pulse = (t == 10) ? 4'h1 : 4'h0;
      e_led  = (t >= 11 && t <= 14);
      e_busy = (t >= 11 && t <= 17);
      checks++;
      if (led_out !== {3'b000, e_led} || busy !== {3'b000, e_busy} || drop !== 4'h0) begin
        errors++;
        $display("FAIL single_blink cyc%0d: led=%h busy=%h drop=%h, required led=%h busy=%h drop=0",
                 t, led_out, busy, drop, {3'b000, e_led}, {3'b000, e_busy});
      end
    end
  endtask

  task automatic test_channels();
    logic e02, e3, b02, b3;
    begin_test();
    for (int i = 0; i < 18; i++) begin
      step();
      evt_pulse = (t == 5) ? 4'b0101 : (t == 7) ? 4'b1000 : 4'h0;
      e02 = (t >= 6 && t <= 9);
      b02 = (t >= 6 && t <= 12);
      e3  = (t >= 8 && t <= 11);
      b3  = (t >= 8 && t <= 14);
      checks++;
      if (led_out !== {e3, e02, 1'b0, e02} || busy !== {b3, b02, 1'b0, b02} || drop !== 4'h0) begin
        errors++;
        $display("FAIL channels cyc%0d: led=%h busy=%h drop=%h, required led=%h busy=%h",
                 t, led_out, busy, drop, {e3, e02, 1'b0, e02}, {b3, b02, 1'b0, b02});
      end
    end
  endtask

`ifndef LED_QUEUE_EN
  task automatic test_retrigger();
    logic e_led, e_busy;
    begin_test();
    for (int i = 0; i < 24; i++) begin
      step();
      evt_pulse = (t == 10 || t == 12) ? 4'h1 : 4'h0;
      e_led  = (t >= 11 && t <= 16);
      e_busy = (t >= 11 && t <= 19);
      checks++;
      if (led_out !== {3'b000, e_led} || busy !== {3'b000, e_busy} || drop !== 4'h0) begin
        errors++;
        $display("FAIL retrigger cyc%0d: led=%h busy=%h drop=%h, required led=%h busy=%h drop=0",
                 t, led_out, busy, drop, {3'b000, e_led}, {3'b000, e_busy});
      end
    end
  endtask

  task automatic test_pending_drop();
    logic e_led, e_busy, e_drop;
    begin_test();
    for (int i = 0; i < 28; i++) begin
      step();
      evt_pulse = (t == 10 || t == 16 || t == 17) ? 4'h1 : 4'h0;
      e_led  = (t >= 11 && t <= 14) || (t >= 18 && t <= 21);
      e_busy = (t >= 11 && t <= 24);
      e_drop = (t == 18);
      checks++;
      if (led_out !== {3'b000, e_led} || busy !== {3'b000, e_busy} || drop !== {3'b000, e_drop}) begin
        errors++;
        $display("FAIL pending_drop cyc%0d: led=%h busy=%h drop=%h, required led=%h busy=%h drop=%h",
                 t, led_out, busy, drop, {3'b000, e_led}, {3'b000, e_busy}, {3'b000, e_drop});
      end
    end
  endtask
`else
  task automatic test_queue();
    logic e_led, e_busy, e_drop;
    begin_test();
    for (int i = 0; i < 34; i++) begin
      step();
      evt_pulse = (t >= 10 && t <= 13) ? 4'h1 : 4'h0;
      e_led  = (t >= 11 && t <= 14) || (t >= 18 && t <= 21) || (t >= 25 && t <= 28);
      e_busy = (t >= 11 && t <= 31);
      e_drop = (t == 14);
      checks++;
      if (led_out !== {3'b000, e_led} || busy !== {3'b000, e_busy} || drop !== {3'b000, e_drop}) begin
        errors++;
        $display("FAIL queue cyc%0d: led=%h busy=%h drop=%h, required led=%h busy=%h drop=%h",
                 t, led_out, busy, drop, {3'b000, e_led}, {3'b000, e_busy}, {3'b000, e_drop});
      end
    end
  endtask
`endif

  task automatic test_mid_reset();
    logic e_led, e_busy;
    begin_test();
    for (int i = 0; i < 30; i++) begin
      step();
      evt_pulse = (t == 10 || t == 20) ? 4'b0010 : 4'h0;
      rst       = (t == 12);
      e_led  = (t >= 11 && t <= 12) || (t >= 21 && t <= 24);
      e_busy = (t >= 11 && t <= 12) || (t >= 21 && t <= 27);
      checks++;
      if (led_out !== {2'b00, e_led, 1'b0} || busy !== {2'b00, e_busy, 1'b0} || drop !== 4'h0) begin
        errors++;
        $display("FAIL mid_reset cyc%0d: led=%h busy=%h drop=%h, required led=%h busy=%h drop=0",
                 t, led_out, busy, drop, {2'b00, e_led, 1'b0}, {2'b00, e_busy, 1'b0});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    t         = 0;
    rst       = 1'b1;
    evt_pulse = 4'h0;
    test_reset();
    test_single_blink();
    test_channels();
`ifndef LED_QUEUE_EN
    test_retrigger();
    test_pending_drop();
`else
    test_queue();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
